iencode: RTL and testbench

IENCODE -- requirements
Module: iencode

---
 rtl/iencode.sv | 114 +++++++++++
 tb/tb_iencode.sv | 313 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/iencode.sv
// Instruction-field encoder: packs request fields into 32-bit instruction words
// and streams them through a small FIFO onto an instruction-memory write port.
module iencode #(
  parameter int ADDR_W = 10,
  parameter int DEPTH  = 4,
  parameter int BASE   = 0
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [3:0]        opcode,
  input  logic [25:0]       imm26,
  input  logic [18:0]       imm19,
  input  logic [11:0]       imm12,
  input  logic [8:0]        imm9,
  input  logic [5:0]        shamt,
  input  logic [4:0]        rm,
  input  logic [4:0]        rn,
  input  logic [4:0]        rd,
  input  logic              clear,
  output logic              mem_wr_en,
  input  logic              mem_ready,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [31:0]       mem_wdata,
  output logic              err,
  output logic [7:0]        err_count
);

  localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  localparam logic [3:0] OP_ADDI = 4'd1;
  localparam logic [3:0] OP_ADDS = 4'd2;
  localparam logic [3:0] OP_BLT  = 4'd3;
  localparam logic [3:0] OP_B    = 4'd4;
  localparam logic [3:0] OP_CBZ  = 4'd5;
  localparam logic [3:0] OP_LDUR = 4'd6;
  localparam logic [3:0] OP_LSL  = 4'd7;
  localparam logic [3:0] OP_LSR  = 4'd8;
  localparam logic [3:0] OP_MUL  = 4'd9;
  localparam logic [3:0] OP_STUR = 4'd10;
  localparam logic [3:0] OP_SUBS = 4'd11;

  logic [31:0] fifo_mem [DEPTH];
  logic [PW-1:0] rptr, wptr;
  logic [PW:0]   count;
  logic [31:0]   word;
  logic          valid_op;
  logic          accept, push, pop;

  // Both handshakes transfer on a rising edge where valid and ready are both high;
  // ready never depends on valid, and valid-side data must hold until the transfer.
  assign in_ready  = (count < (PW+1)'(DEPTH));
  assign accept    = in_valid & in_ready;
  assign push      = accept & valid_op;
  assign mem_wr_en = (count != '0);
  assign pop       = mem_wr_en & mem_ready;
  assign mem_wdata = mem_wr_en ? fifo_mem[rptr] : 32'h0;

  always_comb begin
    word     = 32'h0;
    valid_op = 1'b1;
    case (opcode)
      OP_ADDI: word = {10'h244, imm12, rn, rd};
      OP_ADDS: word = {11'h558, rm, shamt, rn, rd};
      OP_BLT:  word = {8'h54, imm19, 5'h0B};
      OP_B:    word = {6'h05, imm26};
      OP_CBZ:  word = {8'hB4, imm19, rd};
      OP_LDUR: word = {11'h7C2, imm9, 2'b00, rn, rd};
      OP_LSL:  word = {11'h69B, rm, shamt, rn, rd};
      OP_LSR:  word = {11'h69A, rm, shamt, rn, rd};
      OP_MUL:  word = {11'h4D8, rm, 6'h1F, rn, rd};
      OP_STUR: word = {11'h7C0, imm9, 2'b00, rn, rd};
      OP_SUBS: word = {11'h758, rm, shamt, rn, rd};
      default: valid_op = 1'b0;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      rptr      <= '0;
      wptr      <= '0;
      count     <= '0;
      mem_addr  <= ADDR_W'(BASE);
      err       <= 1'b0;
      err_count <= 8'h0;
    end else if (clear) begin
      // err_count survives a flush; the in-flight accept is dropped entirely
      rptr     <= '0;
      wptr     <= '0;
      count    <= '0;
      mem_addr <= ADDR_W'(BASE);
      err      <= 1'b0;
    end else begin
      if (push) wptr <= wptr + PW'(1);
      if (pop) begin
        rptr     <= rptr + PW'(1);
        mem_addr <= mem_addr + ADDR_W'(1);
      end
      case ({push, pop})
        2'b10:   count <= count + (PW+1)'(1);
        2'b01:   count <= count - (PW+1)'(1);
        default: count <= count;
      endcase
      err <= accept & ~valid_op;
      if (accept && !valid_op && err_count != 8'hFF) err_count <= err_count + 8'd1;
    end
  end

  always_ff @(posedge clk) begin
    if (push && !clear) fifo_mem[wptr] <= word;
  end

endmodule

// File: tb/tb_iencode.sv
// Bench for iencode: directed vectors plus random traffic, checked every cycle
// against a queue-based reference of the encoder, FIFO and write port.
module tb_iencode;
  localparam int ADDR_W = 10;
  localparam int DEPTH  = 4;
  localparam int BASE   = 0;

  logic        clk, reset;
  logic        in_valid, in_ready;
  logic [3:0]  opcode;
  logic [25:0] imm26;
  logic [18:0] imm19;
  logic [11:0] imm12;
  logic [8:0]  imm9;
  logic [5:0]  shamt;
  logic [4:0]  rm, rn, rd;
  logic        clear, mem_wr_en, mem_ready, err;
  logic [ADDR_W-1:0] mem_addr;
  logic [31:0] mem_wdata;
  logic [7:0]  err_count;

  logic        in_ready2, mem_wr_en2, err2;
  logic [1:0]  mem_addr2;
  logic [31:0] mem_wdata2;
  logic [7:0]  err_count2;

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  iencode #(.ADDR_W(ADDR_W), .DEPTH(DEPTH), .BASE(BASE)) u_dut (
    .clk(clk), .reset(reset), .in_valid(in_valid), .in_ready(in_ready),
    .opcode(opcode), .imm26(imm26), .imm19(imm19), .imm12(imm12), .imm9(imm9),
    .shamt(shamt), .rm(rm), .rn(rn), .rd(rd), .clear(clear),
    .mem_wr_en(mem_wr_en), .mem_ready(mem_ready), .mem_addr(mem_addr),
    .mem_wdata(mem_wdata), .err(err), .err_count(err_count)
  );

  iencode #(.ADDR_W(2), .DEPTH(DEPTH), .BASE(BASE)) u_dut2 (
    .clk(clk), .reset(reset), .in_valid(in_valid), .in_ready(in_ready2),
    .opcode(opcode), .imm26(imm26), .imm19(imm19), .imm12(imm12), .imm9(imm9),
    .shamt(shamt), .rm(rm), .rn(rn), .rd(rd), .clear(clear),
    .mem_wr_en(mem_wr_en2), .mem_ready(mem_ready), .mem_addr(mem_addr2),
    .mem_wdata(mem_wdata2), .err(err2), .err_count(err_count2)
  );

  // scoreboard state
  logic [31:0] exp_q[$];
  int          exp_addr, exp_errcnt;
  logic        exp_err;
  int          n_checks, n_errors, n_writes;
  logic        last_acc;
  logic        obs_wr, obs_ready, obs_err;
  logic [31:0] obs_wdata, obs_addr, obs_errcnt;
  int          addr2_log[$];

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s got=%h exp=%h at %0t", tag, got, exp, $time);
    end
  endtask

  // Reference encoder built from opcode prefixes and field bit positions.
  function automatic logic [31:0] ref_word(input int op, input logic [31:0] i26,
      input logic [31:0] i19, input logic [31:0] i12, input logic [31:0] i9,
      input logic [31:0] sh, input logic [31:0] vrm, input logic [31:0] vrn,
      input logic [31:0] vrd);
    logic [31:0] op11;
    op11 = 0;
    case (op)
      4:  return (32'h05 << 26) + i26;
      5:  return (32'hB4 << 24) + (i19 << 5) + vrd;
      3:  return (32'h54 << 24) + (i19 << 5) + 32'd11;
      1:  return (32'h244 << 22) + (i12 << 10) + (vrn << 5) + vrd;
      6, 10: begin
        op11 = (op == 6) ? 32'h7C2 : 32'h7C0;
        return (op11 << 21) + (i9 << 12) + (vrn << 5) + vrd;
      end
      default: begin
        case (op)
          8:  op11 = 32'h69A;
          7:  op11 = 32'h69B;
          11: op11 = 32'h758;
          2:  op11 = 32'h558;
          default: op11 = 32'h4D8;
        endcase
        if (op == 9) sh = 32'd31;
        return (op11 << 21) + (vrm << 16) + (sh << 10) + (vrn << 5) + vrd;
      end
    endcase
  endfunction

  // One clock: sample and check at the falling edge, advance the model, then
  // return just after the rising edge so drivers can change inputs.
  task automatic tick();
    logic acc, pop, bad;
    @(negedge clk);
    obs_wr = mem_wr_en; obs_wdata = mem_wdata; obs_addr = 32'(mem_addr);
    obs_ready = in_ready; obs_err = err; obs_errcnt = 32'(err_count);
    check("wr_en", 32'(mem_wr_en), 32'(exp_q.size() != 0));
    check("in_ready", 32'(in_ready), 32'(exp_q.size() < DEPTH));
    check("err", 32'(err), 32'(exp_err));
    check("err_count", 32'(err_count), exp_errcnt);
    check("addr", 32'(mem_addr), exp_addr);
    check("wdata", mem_wdata, (exp_q.size() != 0) ? exp_q[0] : 32'h0);
    check("w2_wr_en", 32'(mem_wr_en2), 32'(exp_q.size() != 0));
    check("w2_addr", 32'(mem_addr2), exp_addr % 4);
    check("w2_wdata", mem_wdata2, (exp_q.size() != 0) ? exp_q[0] : 32'h0);
    if (mem_wr_en2 && mem_ready) addr2_log.push_back(int'(mem_addr2));
    acc = in_valid && (exp_q.size() < DEPTH);
    pop = (exp_q.size() != 0) && mem_ready;
    bad = (opcode == 4'd0) || (opcode > 4'd11);
    last_acc = acc;
    if (clear) begin
      exp_q.delete();
      exp_addr = BASE;
      exp_err = 1'b0;
    end else begin
      exp_err = acc && bad;
      if (acc && bad && exp_errcnt < 255) exp_errcnt++;
      if (pop) begin
        void'(exp_q.pop_front());
        exp_addr = (exp_addr + 1) % (1 << ADDR_W);
        n_writes++;
      end
      if (acc && !bad)
        exp_q.push_back(ref_word(int'(opcode), 32'(imm26), 32'(imm19), 32'(imm12),
                                 32'(imm9), 32'(shamt), 32'(rm), 32'(rn), 32'(rd)));
    end
    @(posedge clk);
    #1;
  endtask

  // driver tasks
  task automatic send(input logic [3:0] op);
    int k;
    opcode = op;
    in_valid = 1'b1;
    k = 0;
    last_acc = 1'b0;
    while (!last_acc && k < 100) begin
      tick();
      k++;
    end
    if (!last_acc) check("accept_timeout", 32'd0, 32'd1);
    in_valid = 1'b0;
  endtask

  task automatic randomize_fields();
    imm26 = 26'($urandom); imm19 = 19'($urandom); imm12 = 12'($urandom);
    imm9 = 9'($urandom); shamt = 6'($urandom);
    rm = 5'($urandom); rn = 5'($urandom); rd = 5'($urandom);
  endtask

  task automatic apply_reset();
    in_valid = 1'b0;
    clear = 1'b0;
    reset = 1'b1;
    #1;
    check("rst_wr_en", 32'(mem_wr_en), 32'd0);
    check("rst_addr", 32'(mem_addr), BASE);
    check("rst_wdata", mem_wdata, 32'h0);
    check("rst_err", 32'(err), 32'd0);
    check("rst_err_count", 32'(err_count), 32'd0);
    check("rst_in_ready", 32'(in_ready), 32'd1);
    check("rst_w2_addr", 32'(mem_addr2), BASE);
    exp_q.delete();
    exp_addr = BASE;
    exp_err = 1'b0;
    exp_errcnt = 0;
    @(negedge clk);
    @(negedge clk);
    reset = 1'b0;
    @(posedge clk);
    #1;
  endtask

  initial begin
    int w0;
    n_checks = 0; n_errors = 0; n_writes = 0;
    reset = 1'b0; in_valid = 1'b0; clear = 1'b0; mem_ready = 1'b1; opcode = 4'd0;
    imm26 = '0; imm19 = '0; imm12 = '0; imm9 = '0; shamt = '0; rm = '0; rn = '0; rd = '0;
    #1;
    apply_reset();

    // ADDI rd=2 rn=1 imm12=5
    rd = 5'd2; rn = 5'd1; imm12 = 12'h005;
    send(4'd1);
    tick();
    check("addi_wr", 32'(obs_wr), 32'd1);
    check("addi_addr", obs_addr, 32'd0);
    check("addi_word", obs_wdata, 32'h91001422);

    // B then MUL back to back
    apply_reset();
    imm26 = 26'h3;
    send(4'd4);
    rd = 5'd3; rn = 5'd1; rm = 5'd2; shamt = 6'd0;
    send(4'd9);
    check("b_word", obs_wdata, 32'h14000003);
    check("b_addr", obs_addr, 32'd0);
    tick();
    check("mul_word", obs_wdata, 32'h9B027C23);
    check("mul_addr", obs_addr, 32'd1);

    // LDUR and BLT (rd ignored by BLT)
    apply_reset();
    rd = 5'd4; rn = 5'd5; imm9 = 9'd8;
    send(4'd6);
    imm19 = 19'd2; rd = 5'd7;
    send(4'd3);
    check("ldur_word", obs_wdata, 32'hF84080A4);
    tick();
    check("blt_word", obs_wdata, 32'h5400004B);

    // back-pressure: 4 accepted, 5th blocked until the port drains
    apply_reset();
    mem_ready = 1'b0;
    w0 = n_writes;
    for (int i = 0; i < 4; i++) begin
      randomize_fields();
      send(4'($urandom_range(1, 11)));
    end
    randomize_fields();
    opcode = 4'd7;
    in_valid = 1'b1;
    tick();
    check("full_in_ready", 32'(obs_ready), 32'd0);
    check("full_no_accept", 32'(last_acc), 32'd0);
    mem_ready = 1'b1;
    send(4'd7);
    repeat (6) tick();
    check("full_writes", n_writes - w0, 32'd5);

    // bad opcodes
    apply_reset();
    send(4'd0);
    tick();
    check("bad0_err", 32'(obs_err), 32'd1);
    check("bad0_nowr", 32'(obs_wr), 32'd0);
    send(4'd15);
    tick();
    check("bad15_err", 32'(obs_err), 32'd1);
    tick();
    check("bad_err_low", 32'(obs_err), 32'd0);
    check("bad_count2", obs_errcnt, 32'd2);
    in_valid = 1'b1;
    for (int i = 0; i < 256; i++) begin
      opcode = 4'($urandom_range(12, 15));
      tick();
    end
    in_valid = 1'b0;
    tick();
    check("bad_count_sat", obs_errcnt, 32'd255);

    // clear with an in-flight accept; err_count must survive
    mem_ready = 1'b0;
    randomize_fields(); send(4'd2);
    randomize_fields(); send(4'd5);
    randomize_fields();
    opcode = 4'd11; in_valid = 1'b1; clear = 1'b1;
    tick();
    clear = 1'b0; in_valid = 1'b0;
    tick();
    check("clear_wr", 32'(obs_wr), 32'd0);
    check("clear_addr", obs_addr, BASE);
    check("clear_err_count", obs_errcnt, 32'd255);

    // asynchronous reset mid-stream
    apply_reset();
    randomize_fields(); send(4'd4);
    randomize_fields(); send(4'd5);
    tick();
    check("pre_rst_wr", 32'(obs_wr), 32'd1);
    w0 = n_writes;
    apply_reset();
    mem_ready = 1'b1;
    repeat (5) tick();
    check("post_rst_writes", n_writes - w0, 32'd0);

    // address wrap on the ADDR_W=2 instance
    apply_reset();
    addr2_log.delete();
    for (int i = 0; i < 5; i++) begin
      randomize_fields();
      send(4'($urandom_range(1, 11)));
    end
    repeat (4) tick();
    check("w2_log_len", addr2_log.size(), 32'd5);
    for (int i = 0; i < 5 && i < addr2_log.size(); i++)
      check("w2_wrap_seq", addr2_log[i], i % 4);

    // random traffic
    apply_reset();
    for (int i = 0; i < 800; i++) begin
      randomize_fields();
      opcode = 4'($urandom_range(0, 15));
      in_valid = ($urandom_range(0, 2) != 0);
      mem_ready = ($urandom_range(0, 3) != 0);
      clear = ($urandom_range(0, 60) == 0);
      tick();
    end
    in_valid = 1'b0; clear = 1'b0; mem_ready = 1'b1;
    repeat (8) tick();
    check("drain_empty", exp_q.size(), 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
